// File: rtl/aes_pkg.sv
// Package for the AES MixColumns engine.
// Holds the engine state type, the AES reduction polynomial, the column type and the
// GF(2^8) multiply-by-constant helpers used by the column mixer.
package aes_pkg;

  // Engine state machine states.
  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1b;

  // One 32-bit state column; byte 0 (bits [7:0]) is row 0.
  typedef logic [31:0] col_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // 9 = 8 + 1
  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  // b = 8 + 2 + 1
  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  // d = 8 + 4 + 1
  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  // e = 8 + 4 + 2
  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns for a single 32-bit column.
// Ports:
//   col     - input column, byte 0 = row 0
//   inv     - 1 selects InvMixColumns (only when AES_INV_MIXCOL_EN is defined)
//   col_out - mixed column
// Build option AES_INV_MIXCOL_EN: when undefined the inverse multipliers are not built and
// inv is ignored (forward only).
module aes_mix_column
  import aes_pkg::*;
(
  input  col_t col,
  input  logic inv,
  output col_t col_out
);

  logic [7:0] a0, a1, a2, a3;
  col_t       fwd_col;

  assign a0 = col[7:0];
  assign a1 = col[15:8];
  assign a2 = col[23:16];
  assign a3 = col[31:24];

  assign fwd_col[7:0]   = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
  assign fwd_col[15:8]  = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
  assign fwd_col[23:16] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
  assign fwd_col[31:24] = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);

`ifdef AES_INV_MIXCOL_EN
  col_t inv_col;

  assign inv_col[7:0]   = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
  assign inv_col[15:8]  = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
  assign inv_col[23:16] = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
  assign inv_col[31:24] = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);

  assign col_out = inv ? inv_col : fwd_col;
`else
  // Forward-only build: direction select has no function.
  logic unused_inv;
  assign unused_inv = inv;
  assign col_out    = fwd_col;
`endif

endmodule

// File: rtl/aes_mix_columns_engine.sv
// Handshaked AES MixColumns stage: forward, inverse or bypass on one 128-bit state,
// COLS_PER_CYCLE columns per clock, result held until taken downstream.
// Parameter:
//   COLS_PER_CYCLE - columns per cycle, 1, 2 or 4
// Ports:
//   clk, rst                     - clock, async active-low reset
//   in_valid/in_ready/in_data    - input state handshake
//   in_inv, in_bypass            - direction / bypass, sampled on accept
//   out_valid/out_ready/out_data - result handshake, out_data held while out_valid
//   busy                         - high while computing or holding a result
// Build option AES_INV_MIXCOL_EN: enables the inverse path (see aes_mix_column).
module aes_mix_columns_engine
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned NumSteps = 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  LastCnt  = 2'(NumSteps - 1);

  state_e         state_q;
  logic [127:0]   work_q, res_q, res_d;
  logic           inv_q, bypass_q, out_valid_q;
  logic [1:0]     col_cnt_q;
  logic           accept;

  col_t cols_in  [COLS_PER_CYCLE];
  col_t cols_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_col
    aes_mix_column u_col (
      .col     (cols_in[g]),
      .inv     (inv_q),
      .col_out (cols_out[g])
    );
  end

  // Select the columns of the current step and merge their results into the result register.
  always_comb begin
    res_d = res_q;
    for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
      cols_in[g] = work_q[32 * (int'(col_cnt_q) * int'(COLS_PER_CYCLE) + g) +: 32];
      if (state_q == StBusy) begin
        res_d[32 * (int'(col_cnt_q) * int'(COLS_PER_CYCLE) + g) +: 32] =
            bypass_q ? cols_in[g] : cols_out[g];
      end
    end
  end

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      res_q       <= '0;
      inv_q       <= 1'b0;
      bypass_q    <= 1'b0;
      col_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            work_q    <= in_data;
            inv_q     <= in_inv;
            bypass_q  <= in_bypass;
            col_cnt_q <= '0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          res_q <= res_d;
          if (col_cnt_q == LastCnt) begin
            col_cnt_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            col_cnt_q <= col_cnt_q + 2'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            // Back-to-back accept skips the idle bubble.
            if (accept) begin
              work_q    <= in_data;
              inv_q     <= in_inv;
              bypass_q  <= in_bypass;
              col_cnt_q <= '0;
              state_q   <= StBusy;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_mix_columns_engine.md
# aes_mix_columns_engine

Parametrised, handshaked AES MixColumns stage for the round datapath. It accepts one 128-bit state per transaction and applies forward MixColumns, inverse MixColumns, or bypass (final round) column by column, COLS_PER_CYCLE columns per clock. It holds the result until the downstream consumer takes it, and sits between ShiftRows and AddRoundKey in the iterative round loop.

## Interface
- COLS_PER_CYCLE, default 1, number of columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  state offered on in_data
- in_ready  output  1  engine can accept a state this cycle
- in_data  input  128  state; byte i = bits [8i+7:8i]; column c = bytes 4c..4c+3; byte 4c = row 0
- in_inv  input  1  1 = InvMixColumns; sampled on accept
- in_bypass  input  1  1 = pass state unchanged; sampled on accept; overrides in_inv
- out_valid  output  1  result on out_data is valid
- out_ready  input  1  consumer takes the result
- out_data  output  128  result, same byte layout as in_data
- busy  output  1  high in BUSY or DONE

## Operation
- N = 4 / COLS_PER_CYCLE compute cycles per state.
- States:
  - IDLE
    - in_ready = 1
    - on in_valid: latch in_data into work register, latch in_inv and in_bypass, set col_cnt = 0, go to BUSY.
  - BUSY
    - each cycle, columns col_cnt*C .. col_cnt*C+C-1 are computed from the work register and written into the result register; col_cnt increments.
    - on the edge where col_cnt == N-1: go to DONE and set out_valid.
  - DONE
    - out_valid = 1 and out_data is held stable.
    - on out_ready: if in_valid is also high, accept the new state and go to BUSY in the same edge; otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready; it has no dependence on in_valid.
- Forward column: r0 = 2a0^3a1^a2^a3, r1 = a0^2a1^3a2^a3, r2 = a0^a1^2a2^3a3, r3 = 3a0^a1^a2^2a3.
- Inverse column uses coefficients 0e, 0b, 0d, 09 with the same rotation.
- Arithmetic:
  - xtime(b) = (b<<1)[7:0] ^ (b[7] ? 8'h1b : 8'h00), applied per byte using that byte's own MSB.
  - 3b = xtime(b)^b; higher multiples are built from repeated xtime.
- Bypass: result = work register, with the same N-cycle latency.
- in_data, in_inv and in_bypass are ignored unless accepted. Changes on them during BUSY have no effect.
- COLS_PER_CYCLE=4: BUSY lasts one cycle.

## Timing
- Reset values:
  - state = IDLE, col_cnt = 0
  - out_valid = 0, out_data = 128'h0, busy = 0
  - in_ready = 1 once rst deasserts
- rst is asserted asynchronously and released synchronously by the system reset block.
- Latency: out_valid rises N cycles after the accept edge (N=4 for C=1, 2 for C=2, 1 for C=4).
- Throughput: one state per N+1 cycles if out_ready is held high. The DONE→BUSY back-to-back accept removes the IDLE bubble.
- Backpressure: out_valid stays high and out_data is frozen for any number of cycles with out_ready low.
- Reset mid-operation: the in-flight state is discarded, out_valid drops immediately, and the engine restarts in IDLE.
- out_ready high while not in DONE is ignored.

## Configuration
- AES_INV_MIXCOL_EN
  - defined: inverse multipliers are synthesised and in_inv selects the direction.
  - undefined: the inverse logic is removed, in_inv is ignored, and forward is always used. Port list is identical in both cases.

## Structure
- Package aes_pkg holds:
  - the state-machine enum type (IDLE/BUSY/DONE)
  - constant AES_POLY = 8'h1b
  - functions xtime, gf_mul2/3/9/b/d/e
  - typedef for a 32-bit column
- Sub-module aes_mix_column: one combinational 32-bit column, with inputs col and inv and output col_out. It is instantiated COLS_PER_CYCLE times, and the inv path is guarded by AES_INV_MIXCOL_EN.

## Test plan
- Forward, C=1: column db 13 53 45 in column 0, remaining columns f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6 → columns 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6. out_valid rises 4 cycles after accept.
- Inverse (macro defined), C=2: input columns 8e 4d a1 bc, 9f dc 58 9d, d5 d5 d7 d6, 4d 7e bd f8 → db 13 53 45, f2 0a 22 5c, d4 d4 d4 d5, 2d 26 31 4c. Latency 2.
- Bypass, C=4: in_bypass=1 and in_inv=1 with in_data=0x00112233…ff → identical out_data after 1 cycle.
- Backpressure: out_ready low for 10 cycles in DONE → out_data stable and in_ready=0 throughout. Then out_ready and in_valid are raised together → new state accepted that same edge.
- Reset during BUSY (cycle 2 of 4): assert rst → out_valid=0 and busy=0 immediately. After release, the next state completes correctly with latency 4.
- Macro undefined: in_inv=1 on column d4 bf 5d 30 → forward result 04 66 81 e5.
